// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the constants that tie the 1-bit cell to its controller.
package sub_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Borrow-in of the first (LSB) cell evaluation of every operation.
  localparam logic BORROW_INIT = 1'b0;

endpackage

// File: rtl/subtractor_bit_cell.sv
// Combinational 1-bit full subtractor built from two half subtractors and an
// OR of their borrows.
module subtractor_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // first half subtractor: a - b
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // second half subtractor: d1 - bin
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (a - b) with valid/ready on both sides.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             bflop;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic shift_en;
  logic last;
  logic cell_d;
  logic cell_bout;

  subtractor_bit_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bflop),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    shift_en  = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        last     = (cnt == CNT_LAST);
        if (cnt == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result enters at the MSB and walks down, so after WIDTH shifts bit i is in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      bflop   <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        bflop <= BORROW_INIT;
        cnt   <= '0;
      end else if (shift_en) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        diff_sr <= (diff_sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
        bflop   <= cell_bout;
        cnt     <= cnt + 1'b1;
      end
    end
  end

  assign diff       = diff_sr;
  assign borrow_out = bflop;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // On the last shift cell_d is the result MSB about to land in diff_sr.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (last) ovf_q <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: directed tests on WIDTH=8,
// random handshake sweeps on WIDTH=1 and WIDTH=16, scoreboard-based.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic iv8, ir8, ov8, or8, bo8, of8;
  logic [7:0] a8, b8, d8;
  logic iv1, ir1, ov1, or1, bo1, of1;
  logic [0:0] a1, b1, d1;
  logic iv16, ir16, ov16, or16, bo16, of16;
  logic [15:0] a16, b16, d16;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8), .ovf(of8)
  );
  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .borrow_out(bo1), .ovf(of1)
  );
  serial_subtractor_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .diff(d16), .borrow_out(bo16), .ovf(of16)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q8[$];
  logic [31:0] qr[$];
  localparam logic [31:0] SB_EMPTY = 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents one operation for one cycle, records the expected result.
  task automatic send8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    logic o;
    int g;
    g = 0;
    while (!ir8 && g < 100) begin @(posedge clk); #1; g++; end
    check("in_ready_wait", {31'd0, ir8}, 32'd1);
    r = {1'b0, a} - {1'b0, b};
`ifdef SERIAL_SUB_OVF_EN
    o = (a[7] != b[7]) && (r[7] != a[7]);
`else
    o = 1'b0;
`endif
    q8.push_back({22'd0, o, r});
    iv8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  // Waits for out_valid (lat counts cycles with the accept cycle as 0), compares, consumes.
  task automatic recv8(input int start, output int lat);
    logic [31:0] exp;
    lat = start;
    while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("out_valid_wait", {31'd0, ov8}, 32'd1);
    exp = (q8.size() != 0) ? q8.pop_front() : SB_EMPTY;
    check("result8", {22'd0, of8, bo8, d8}, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int issued, done, cyc;
    logic [31:0] exp;
    logic [31:0] snap;
    logic [16:0] r16;
    logic [1:0] r1;

    rst = 1'b1;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0;
    iv1 = 0; or1 = 0; a1 = 0; b1 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {27'd0, ir8, ov8, bo8, of8, |d8}, {27'd0, 5'b10000});
    rst = 1'b0;

    // basic operation and latency
    or8 = 1'b1;
    send8(8'd100, 8'd37);
    recv8(1, lat);
    check("latency", lat, 32'd9);
    check("ov_one_cycle", {30'd0, ov8, ir8}, {30'd0, 2'b01});

    send8(8'd0, 8'd1);
    recv8(1, lat);
    send8(8'hA5, 8'hA5);
    recv8(1, lat);

    // backpressure in DONE, ignored in_valid pulses
    or8 = 1'b0;
    send8(8'd200, 8'd50);
    repeat (3) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      iv8 = 1'b0;
    end
    cyc = 0;
    while (!ov8 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    exp = (q8.size() != 0) ? q8[0] : SB_EMPTY;
    snap = {22'd0, of8, bo8, d8};
    check("held_result", snap, exp);
    repeat (5) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      iv8 = 1'b0;
      check("hold_handshake", {30'd0, ov8, ir8}, {30'd0, 2'b10});
      check("hold_data", {22'd0, of8, bo8, d8}, snap);
    end
    or8 = 1'b1;
    recv8(0, lat);
    check("done_to_idle", {30'd0, ov8, ir8}, {30'd0, 2'b01});
    repeat (3) @(posedge clk);
    #1;
    check("no_spurious_op", {31'd0, ov8}, 32'd0);

    // reset in the 4th SHIFT cycle aborts the operation
    send8(8'd55, 8'd9);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_reset", {28'd0, ir8, ov8, bo8, |d8}, {28'd0, 4'b1000});
    if (q8.size() != 0) void'(q8.pop_front());
    send8(8'd20, 8'd7);
    recv8(1, lat);

    // signed overflow cases
    send8(8'h80, 8'h01);
    recv8(1, lat);
    send8(8'h7F, 8'h01);
    recv8(1, lat);
    send8(8'h00, 8'h80);
    recv8(1, lat);
    check("sb8_drained", q8.size(), 32'd0);

    // random sweep, WIDTH=16
    issued = 0; done = 0; cyc = 0; qr.delete();
    while (done < 1000 && cyc < 40000) begin
      iv16 = (issued < 1000) && ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom);
      or16 = ($urandom_range(0, 3) != 0);
      if (iv16 && ir16) begin
        r16 = {1'b0, a16} - {1'b0, b16};
        qr.push_back({15'd0, r16});
        issued++;
      end
      if (ov16 && or16) begin
        exp = (qr.size() != 0) ? qr.pop_front() : SB_EMPTY;
        check("rand16", {15'd0, bo16, d16}, exp);
        done++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv16 = 1'b0;
    check("rand16_count", done, 32'd1000);

    // random sweep, WIDTH=1
    issued = 0; done = 0; cyc = 0; qr.delete();
    while (done < 1000 && cyc < 15000) begin
      iv1 = (issued < 1000) && ($urandom_range(0, 3) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom);
      or1 = ($urandom_range(0, 3) != 0);
      if (iv1 && ir1) begin
        r1 = {1'b0, a1} - {1'b0, b1};
        qr.push_back({30'd0, r1});
        issued++;
      end
      if (ov1 && or1) begin
        exp = (qr.size() != 0) ? qr.pop_front() : SB_EMPTY;
        check("rand1", {30'd0, bo1, d1}, exp);
        done++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv1 = 1'b0;
    check("rand1_count", done, 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
